bcd_conv_sched: RTL and testbench



---
 rtl/bcd_conv_sched_pkg.sv | 17 +
 rtl/bcd_conv_sched_if.sv | 32 +++
 rtl/bcd_conv_sched_dabble_step.sv | 24 ++
 rtl/bcd_conv_sched.sv | 126 ++++++++++++
 tb/tb_bcd_conv_sched.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/bcd_conv_sched_pkg.sv
// Shared types and constants for the time-shared binary-to-BCD converter.
// Defines the FSM state encoding and the datapath widths.
package bcd_sched_pkg;

    localparam int BIN_W       = 8;
    localparam int CONV_CYCLES = 8;
    localparam int BCD_W       = 4;
    localparam int ACC_W       = 3 * BCD_W;
    localparam int CNT_W       = $clog2(CONV_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_e;

endpackage

// File: rtl/bcd_conv_sched_if.sv
// Requester-side bus of the BCD converter: level requests, operands, grant,
// and the tagged result published once per conversion.
interface bcd_conv_sched_if
    import bcd_sched_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IDW  = 2
);

    logic [NREQ-1:0]       req;
    logic [BIN_W*NREQ-1:0] bin_flat;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [BCD_W-1:0]      hun;
    logic [BCD_W-1:0]      ten;
    logic [BCD_W-1:0]      one;

    // Requester / counter side
    modport master (
        output req, bin_flat,
        input  gnt, busy, done, done_id, hun, ten, one
    );

    // Converter side
    modport slave (
        input  req, bin_flat,
        output gnt, busy, done, done_id, hun, ten, one
    );

endinterface

// File: rtl/bcd_conv_sched_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the accumulator left by one, pulling in the next operand bit.
module dabble_step
    import bcd_sched_pkg::*;
(
    input  logic [ACC_W-1:0] i_acc,
    input  logic             i_bit,
    output logic [ACC_W-1:0] o_acc
);

    logic [ACC_W-1:0] w_adj;

    // NOTE: every variable driven here gets a value before any condition, so no latch is inferred.
    always_comb begin
        w_adj = i_acc;
        for (int d = 0; d < 3; d++) begin
            if (i_acc[d*BCD_W +: BCD_W] >= 4'd5)
                w_adj[d*BCD_W +: BCD_W] = i_acc[d*BCD_W +: BCD_W] + 4'd3;
        end
    end

    assign o_acc = {w_adj[ACC_W-2:0], i_bit};

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one iterative 8-bit binary-to-BCD engine
// among NREQ requesters; one conversion takes 10 clock edges.
module bcd_conv_sched
    import bcd_sched_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IDW  = 2
)(
    input  logic             clk,
    input  logic             rst,
    bcd_conv_sched_if.slave  bus
);

    localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

    state_e            r_state;
    state_e            w_next;
    logic [NREQ-1:0]   r_gnt;
    logic [IDW-1:0]    r_gidx;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    w_pick;
    logic              w_any;
    int                w_idx;
    logic [BIN_W-1:0]  r_shreg;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_acc_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;
    logic [IDW-1:0]    r_done_id;
    logic [BCD_W-1:0]  r_hun;
    logic [BCD_W-1:0]  r_ten;
    logic [BCD_W-1:0]  r_one;

    // First requesting index at or after the pointer, wrapping around.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NREQ)
                w_idx = w_idx - NREQ;
            if (!w_any && bus.req[w_idx]) begin
                w_any  = 1'b1;
                w_pick = IDW'(w_idx);
            end
        end
    end

    dabble_step u_step (
        .i_acc (r_acc),
        .i_bit (r_shreg[BIN_W-1]),
        .o_acc (w_acc_nx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = SHIFT;
            SHIFT:   if (r_cnt == CNT_W'(CONV_CYCLES - 1)) w_next = FINISH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt     <= '0;
            r_gidx    <= '0;
            r_ptr     <= '0;
            r_shreg   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_hun     <= '0;
            r_ten     <= '0;
            r_one     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= GNT_ONE << w_pick;
                        r_gidx  <= w_pick;
                        r_shreg <= bus.bin_flat[BIN_W*w_pick +: BIN_W];
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_acc   <= w_acc_nx;
                    r_shreg <= {r_shreg[BIN_W-2:0], 1'b0};
                    r_cnt   <= r_cnt + 1'b1;
                end
                FINISH: begin
                    r_hun     <= r_acc[2*BCD_W +: BCD_W];
                    r_ten     <= r_acc[BCD_W +: BCD_W];
                    r_one     <= r_acc[0 +: BCD_W];
                    r_done    <= 1'b1;
                    r_done_id <= r_gidx;
                    r_gnt     <= '0;
                    r_ptr     <= (r_gidx == IDW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = r_done;
    assign bus.done_id = r_done_id;
    assign bus.hun     = r_hun;
    assign bus.ten     = r_ten;
    assign bus.one     = r_one;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched: latency, digit values, round-robin
// order, operand/req changes mid-conversion, async reset and back-to-back use.
module tb_bcd_conv_sched;

    localparam int NREQ = 3;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    bcd_conv_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    bcd_conv_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic set_op(input int r, input logic [7:0] v);
        bus.bin_flat[8*r +: 8] = v;
    endtask

    // Count negedges until done is seen; start is the number already elapsed.
    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.done) return;
        end
        cyc = -1;
    endtask

    task automatic check_result(input string tag, input int cyc, input int id,
                                input logic [11:0] digits);
        check({tag, "_latency"}, cyc, 10);
        check({tag, "_done"}, 32'(bus.done), 1);
        check({tag, "_id"}, 32'(bus.done_id), id);
        check({tag, "_digits"}, {20'd0, bus.hun, bus.ten, bus.one}, {20'd0, digits});
    endtask

    logic [7:0]  t2_ops  [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199};
    logic [11:0] t2_exp  [6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h199};
    int          t3_ids  [4] = '{0, 1, 2, 0};
    logic [11:0] t3_exp  [4] = '{12'h012, 12'h034, 12'h056, 12'h012};

    initial begin
        int cyc;
        int n_done;
        bus.req      = '0;
        bus.bin_flat = '0;

        // Reset state
        #1;
        check("rst_gnt",  32'(bus.gnt), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_digits", {20'd0, bus.hun, bus.ten, bus.one}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: requester 0, operand 255
        set_op(0, 8'd255);
        bus.req = 3'b001;
        @(negedge clk);
        check("t1_gnt",  32'(bus.gnt), 32'b001);
        check("t1_busy", 32'(bus.busy), 1);
        wait_done(1, cyc);
        check_result("t1", cyc, 0, 12'h255);
        check("t1_gnt_off",  32'(bus.gnt), 0);
        check("t1_busy_off", 32'(bus.busy), 0);
        bus.req = '0;
        @(negedge clk);
        check("t1_pulse", 32'(bus.done), 0);

        // 2: operand sweep through requester 1
        foreach (t2_ops[i]) begin
            set_op(1, t2_ops[i]);
            bus.req = 3'b010;
            wait_done(0, cyc);
            check_result($sformatf("t2_%0d", t2_ops[i]), cyc, 1, t2_exp[i]);
            bus.req = '0;
        end

        // 3: all request; pointer starts at 0 after reset
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_op(0, 8'd12);
        set_op(1, 8'd34);
        set_op(2, 8'd56);
        bus.req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_done(0, cyc);
            check_result($sformatf("t3_%0d", i), cyc, t3_ids[i], t3_exp[i]);
            if (i > 0) bus.req[t3_ids[i]] = 1'b0;
        end

        // 4: operand changed and req dropped mid-conversion
        set_op(2, 8'd59);
        bus.req = 3'b100;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) set_op(2, 8'd0);
            if (cyc == 5) bus.req = '0;
            if (bus.done) break;
        end
        check_result("t4", cyc, 2, 12'h059);

        // 5: asynchronous reset mid-conversion
        set_op(0, 8'd200);
        bus.req = 3'b001;
        repeat (4) @(negedge clk);
        check("t5_busy_pre", 32'(bus.busy), 1);
        rst = 1'b0;
        bus.req = '0;
        #1;
        check("t5_gnt",  32'(bus.gnt), 0);
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_id",   32'(bus.done_id), 0);
        check("t5_digits", {20'd0, bus.hun, bus.ten, bus.one}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("t5_no_done", n_done, 0);
        set_op(1, 8'd123);
        bus.req = 3'b010;
        @(negedge clk);
        check("t5_gnt1", 32'(bus.gnt), 32'b010);
        wait_done(1, cyc);
        check_result("t5", cyc, 1, 12'h123);
        bus.req = '0;

        // 6: back-to-back conversions, outputs hold between pulses
        set_op(0, 8'd58);
        set_op(1, 8'd7);
        bus.req = 3'b011;
        wait_done(0, cyc);
        check_result("t6_a", cyc, 0, 12'h058);
        bus.req[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_hold_done", 32'(bus.done), 0);
        check("t6_hold_id", 32'(bus.done_id), 0);
        check("t6_hold_digits", {20'd0, bus.hun, bus.ten, bus.one}, 32'h058);
        wait_done(5, cyc);
        check_result("t6_b", cyc, 1, 12'h007);
        bus.req = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
